mips_prog_loader: RTL and testbench

Byte-stream program loader for the pipelined MIPS32 core. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into the core's unified instruction/data memory through a single write port. The core is held in reset (`cpu_hold`) until a frame with a correct checksum has been loaded. This is the hardware equivalent of the bench-side preloading of the core's memory words and PC.

---
 rtl/mips_loader_pkg.sv | 29 ++
 rtl/mips_prog_loader_if.sv | 20 ++
 rtl/mips_word_packer.sv | 29 ++
 rtl/mips_prog_loader.sv | 113 +++++++++++
 tb/tb_mips_prog_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_loader_pkg.sv
// Shared definitions for the MIPS program loader.
// Contents: the frame constants, the FSM state encoding and the checksum helpers.
package mips_loader_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    CNT_H,
    CNT_L,
    DATA,
    CSUM,
    RUN
  } loader_state_t;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Whole-frame checksum from the header fields and the XOR of all data words.
  function automatic logic [7:0] frame_csum(input logic [15:0] addr, input logic [15:0] cnt,
                                            input logic [31:0] data_xor);
    return addr[15:8] ^ addr[7:0] ^ cnt[15:8] ^ cnt[7:0] ^
           data_xor[31:24] ^ data_xor[23:16] ^ data_xor[15:8] ^ data_xor[7:0];
  endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// The loader uses the slave modport; the host/memory side uses the master modport.
interface mips_prog_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_word_packer.sv
// Collects four accepted bytes (MSB first) into one big-endian 32-bit word.
module mips_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
    end else if (byte_valid) begin
      shreg    <= {shreg[15:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // The fourth byte completes the word combinationally so the write registers on its own edge.
  assign word      = {shreg, byte_in};
  assign word_done = byte_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/mips_prog_loader.sv
// Framed byte-stream loader: writes words into core memory and holds the core until a good checksum.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  mips_prog_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                err
);

  loader_state_t     state;
  logic [7:0]        addr_hi;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       cnt;
  logic [7:0]        csum;
  logic              accept;
  logic [31:0]       word;
  logic              word_done;

  assign accept = bus.in_valid && bus.in_ready;

  mips_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept && (state == IDLE)),
    .byte_valid (accept && (state == DATA)),
    .byte_in    (bus.in_byte),
    .word       (word),
    .word_done  (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_hi       <= 8'd0;
      addr          <= '0;
      cnt           <= 16'd0;
      csum          <= 8'd0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'd0;
      cpu_hold      <= 1'b1;
      load_done     <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.mem_we   <= 1'b0;
      load_done    <= 1'b0;
      bus.in_ready <= (state != RUN);
      if (accept) begin
        case (state)
          IDLE: begin
            if (bus.in_byte == SYNC) begin
              state <= ADDR_H;
              err   <= 1'b0;
              csum  <= 8'd0;
            end
          end
          ADDR_H: begin
            addr_hi <= bus.in_byte;
            csum    <= csum_update(csum, bus.in_byte);
            state   <= ADDR_L;
          end
          ADDR_L: begin
            // Upper address bits beyond the memory size are simply discarded.
            addr  <= ADDR_W'({addr_hi, bus.in_byte});
            csum  <= csum_update(csum, bus.in_byte);
            state <= CNT_H;
          end
          CNT_H: begin
            cnt[15:8] <= bus.in_byte;
            csum      <= csum_update(csum, bus.in_byte);
            state     <= CNT_L;
          end
          CNT_L: begin
            cnt[7:0] <= bus.in_byte;
            csum     <= csum_update(csum, bus.in_byte);
            state    <= ({cnt[15:8], bus.in_byte} != 16'd0) ? DATA : CSUM;
          end
          DATA: begin
            csum <= csum_update(csum, bus.in_byte);
            if (word_done) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= addr;
              bus.mem_wdata <= word;
              addr          <= addr + 1'b1;
              cnt           <= cnt - 16'd1;
              if (cnt == 16'd1) state <= CSUM;
            end
          end
          CSUM: begin
            if (bus.in_byte == csum) begin
              state        <= RUN;
              load_done    <= 1'b1;
              cpu_hold     <= 1'b0;
              bus.in_ready <= 1'b0;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized frame-level bench for mips_prog_loader against a behavioural frame model.
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_hold, load_done, err;

  mips_prog_loader_if #(.ADDR_W(10)) bus();

  mips_prog_loader #(.ADDR_W(10), .SYNC(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;
  bit use_gaps = 1'b0;

  logic        exp_ready, exp_we, exp_hold, exp_done, exp_err;
  logic [9:0]  exp_addr;
  logic [31:0] exp_data;
  int exp_writes = 0, exp_dones = 0;
  int dut_writes = 0, dut_dones = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Per-cycle comparison of every output against the frame model
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("in_ready",  32'(bus.in_ready),  32'(exp_ready));
      checkOutput("mem_we",    32'(bus.mem_we),    32'(exp_we));
      checkOutput("mem_addr",  32'(bus.mem_addr),  32'(exp_addr));
      checkOutput("mem_wdata", bus.mem_wdata,      exp_data);
      checkOutput("cpu_hold",  32'(cpu_hold),      32'(exp_hold));
      checkOutput("load_done", 32'(load_done),     32'(exp_done));
      checkOutput("err",       32'(err),           32'(exp_err));
      if (bus.mem_we === 1'b1) dut_writes++;
      if (load_done === 1'b1) dut_dones++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_we   = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (use_gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'($urandom);
        tick();
      end
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    exp_ready = 1'b0;
    exp_hold  = 1'b1;
    exp_err   = 1'b0;
    exp_addr  = 10'd0;
    exp_data  = 32'd0;
    rst = 1'b0;
    tick();
    exp_ready = 1'b1;
    checking  = 1'b1;
  endtask

  // Sends one frame; abort_after > 0 asserts reset after that many data bytes
  task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] words[$],
                               input bit corrupt, input int abort_after);
    logic [15:0] n;
    logic [31:0] wx;
    logic [31:0] w;
    logic [7:0]  cs;
    n  = 16'(words.size());
    wx = 32'd0;
    foreach (words[i]) wx ^= words[i];
    cs = frame_csum(addr, n, wx) ^ (corrupt ? 8'h01 : 8'h00);
    send_byte(8'hA5);
    exp_err = 1'b0;
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int k = 0; k < 4 * int'(n); k++) begin
      w = words[k / 4];
      send_byte(w[31 - 8 * (k % 4) -: 8]);
      if (k == abort_after - 1) begin
        do_reset();
        return;
      end
      if (k % 4 == 3) begin
        exp_we   = 1'b1;
        exp_addr = 10'(32'(addr) + 32'(k / 4));
        exp_data = w;
        exp_writes++;
      end
    end
    send_byte(cs);
    if (!corrupt) begin
      exp_done  = 1'b1;
      exp_hold  = 1'b0;
      exp_ready = 1'b0;
      exp_dones++;
    end else begin
      exp_err = 1'b1;
    end
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] empty_q[$];
    logic [15:0] a;
    bit          c;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'd0;
    exp_we = 1'b0;
    exp_done = 1'b0;
    do_reset();
    checkOutput("reset_hold", 32'(cpu_hold), 32'd1);
    checkOutput("reset_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("csum_pin_a", 32'(frame_csum(16'h0000, 16'h0001, 32'h28010078)), 32'h50);
    checkOutput("csum_pin_b", 32'(frame_csum(16'h0005, 16'h0000, 32'h0)), 32'h05);

    $display("[TB] single word frame");
    q = {32'h28010078};
    applyStimulus(16'h0000, q, 1'b0, -1);
    checkOutput("single_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("single_data", bus.mem_wdata, 32'h28010078);
    checkOutput("single_hold", 32'(cpu_hold), 32'd0);
    do_reset();

    $display("[TB] eight word program with gaps");
    use_gaps = 1'b1;
    q = {32'h28010078, 32'h0c631800, 32'h20220000, 32'h00221820,
         32'hac030004, 32'h8c040004, 32'h00000000, 32'hfc000000};
    applyStimulus(16'h0000, q, 1'b0, -1);
    checkOutput("prog_last_addr", 32'(bus.mem_addr), 32'd7);
    checkOutput("prog_last_data", bus.mem_wdata, 32'hfc000000);
    do_reset();

    $display("[TB] bad checksum then recovery");
    q = {32'h28010078};
    applyStimulus(16'h0000, q, 1'b1, -1);
    checkOutput("bad_err", 32'(err), 32'd1);
    checkOutput("bad_hold", 32'(cpu_hold), 32'd1);
    applyStimulus(16'h0000, q, 1'b0, -1);
    checkOutput("recover_err", 32'(err), 32'd0);
    checkOutput("recover_hold", 32'(cpu_hold), 32'd0);
    do_reset();

    $display("[TB] address wrap and truncation");
    q = {32'h11223344, 32'h55667788};
    applyStimulus(16'h03FF, q, 1'b0, -1);
    checkOutput("wrap_addr", 32'(bus.mem_addr), 32'd0);
    do_reset();
    q = {32'hdeadbeef};
    applyStimulus(16'h8078, q, 1'b0, -1);
    checkOutput("trunc_addr", 32'(bus.mem_addr), 32'h078);
    do_reset();

    $display("[TB] garbage then empty frame");
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    applyStimulus(16'h0005, empty_q, 1'b0, -1);
    checkOutput("empty_writes", dut_writes, exp_writes);
    do_reset();

    $display("[TB] reset mid frame");
    q = {32'hcafef00d, 32'h01020304};
    applyStimulus(16'h0010, q, 1'b0, 2);
    checkOutput("abort_hold", 32'(cpu_hold), 32'd1);
    checkOutput("abort_we", 32'(bus.mem_we), 32'd0);
    applyStimulus(16'h0010, q, 1'b0, -1);
    checkOutput("after_abort_addr", 32'(bus.mem_addr), 32'h011);
    do_reset();

    $display("[TB] random frames");
    for (int f = 0; f < 20; f++) begin
      q = {};
      repeat ($urandom_range(1, 5)) q.push_back($urandom);
      a = 16'($urandom);
      c = ($urandom_range(0, 3) == 0);
      applyStimulus(a, q, c, -1);
      if (!c) do_reset();
    end

    tick();
    checkOutput("write_count", dut_writes, exp_writes);
    checkOutput("done_count", dut_dones, exp_dones);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
